// File: rtl/or_16bit_checker_chip.sv
// or_16bit_checker_chip: response checker for a 16-bit OR chip (golden a|b vs supplied out)
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   vector handshake; a vector is taken when both are high
//   in_a, in_b, in_out  operands applied to the chip and the chip's result
//   halt_on_fail        a failing accept moves the checker to HALT
//   clear               synchronous clear of counters, flags, capture and state
//   result_valid        one-cycle verdict pulse, one per accepted vector
//   result_pass         verdict of the last accepted vector
//   diff_mask           bits where in_out differed from in_a | in_b
//   pass_cnt, fail_cnt  saturating verdict counters
//   err                 sticky mismatch flag
//   first_fail_*        capture of the first failing vector
//   halted              checker is in HALT
module or_16bit_checker_chip #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_out,
    input  logic             halt_on_fail,
    input  logic             clear,
    output logic             result_valid,
    output logic             result_pass,
    output logic [WIDTH-1:0] diff_mask,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b,
    output logic [WIDTH-1:0] first_fail_out,
    output logic             halted
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state;
    logic accept;
    logic pass;
    logic [WIDTH-1:0] diff;
    // rst_n is folded in so the checker never advertises readiness while held in reset
    assign in_ready = rst_n & ~clear & (state == RUN);
    assign accept   = in_valid & in_ready;
    assign diff     = in_out ^ (in_a | in_b);
    assign pass     = ~|diff;
    assign halted   = (state == HALT);
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state          <= RUN;
            result_valid   <= 1'b0;
            result_pass    <= 1'b0;
            diff_mask      <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err            <= 1'b0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
            first_fail_out <= '0;
        end else begin
            result_valid <= accept;
            if (accept) begin
                result_pass <= pass;
                diff_mask   <= diff;
                // increment by zero once all-ones, giving saturation without a compare mux
                if (pass) begin
                    pass_cnt <= pass_cnt + {{(CNT_W-1){1'b0}}, ~&pass_cnt};
                end else begin
                    fail_cnt <= fail_cnt + {{(CNT_W-1){1'b0}}, ~&fail_cnt};
                    err      <= 1'b1;
                    if (!err) begin
                        first_fail_a   <= in_a;
                        first_fail_b   <= in_b;
                        first_fail_out <= in_out;
                    end
                    if (halt_on_fail) state <= HALT;
                end
            end
        end
    end
endmodule

// File: tb/tb_or_16bit_checker_chip.sv
// tb_or_16bit_checker_chip: randomized scoreboard bench for or_16bit_checker_chip
module tb_or_16bit_checker_chip;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0, in_b = '0, in_out = '0;
    logic        halt_on_fail = 1'b0;
    logic        clear = 1'b0;
    logic        in_ready, result_valid, result_pass, err, halted;
    logic [15:0] diff_mask, pass_cnt, fail_cnt, ff_a, ff_b, ff_out;
    logic        r2, v2, p2, e2, h2;
    logic [15:0] d2, fa2, fb2, fo2;
    logic [1:0]  pc2, fc2;

    or_16bit_checker_chip dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_out(in_out), .halt_on_fail(halt_on_fail),
        .clear(clear), .result_valid(result_valid), .result_pass(result_pass),
        .diff_mask(diff_mask), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err),
        .first_fail_a(ff_a), .first_fail_b(ff_b), .first_fail_out(ff_out), .halted(halted)
    );

    or_16bit_checker_chip #(.WIDTH(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2),
        .in_a(in_a), .in_b(in_b), .in_out(in_out), .halt_on_fail(halt_on_fail),
        .clear(clear), .result_valid(v2), .result_pass(p2),
        .diff_mask(d2), .pass_cnt(pc2), .fail_cnt(fc2), .err(e2),
        .first_fail_a(fa2), .first_fail_b(fb2), .first_fail_out(fo2), .halted(h2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pass;
        logic [15:0] diff;
        int          pc;
        int          fc;
    } verdict_t;
    verdict_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // reference state: plain totals, saturation applied only when comparing
    int          m_pass, m_fail;
    bit          m_err, m_halt, m_rp;
    logic [15:0] m_diff, m_fa, m_fb, m_fo;

    function automatic int sat(int v, int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_pass = 0; m_fail = 0; m_err = 0; m_halt = 0; m_rp = 0;
        m_diff = '0; m_fa = '0; m_fb = '0; m_fo = '0;
    endtask

    task automatic check_state();
        chk("pass_cnt", pass_cnt, sat(m_pass, 16));
        chk("fail_cnt", fail_cnt, sat(m_fail, 16));
        chk("pass_cnt_w2", pc2, sat(m_pass, 2));
        chk("fail_cnt_w2", fc2, sat(m_fail, 2));
        chk("err", err, m_err);
        chk("halted", halted, m_halt);
        chk("halted_w2", h2, m_halt);
        chk("result_pass", result_pass, m_rp);
        chk("diff_mask", diff_mask, m_diff);
        chk("first_fail_a", ff_a, m_fa);
        chk("first_fail_b", ff_b, m_fb);
        chk("first_fail_out", ff_out, m_fo);
    endtask

    task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] o, input bit hof, input bit clr, input bit rn);
        bit rdy;
        verdict_t e;
        in_valid = v; in_a = a; in_b = b; in_out = o;
        halt_on_fail = hof; clear = clr; rst_n = rn;
        #1;
        rdy = rn && !clr && !m_halt;
        chk("in_ready", in_ready, rdy);
        if (!rn || clr) model_zero();
        else if (v && rdy) begin
            m_diff = o ^ (a | b);
            m_rp = (o == (a | b));
            if (m_rp) m_pass++;
            else begin
                m_fail++;
                if (!m_err) begin m_fa = a; m_fb = b; m_fo = o; end
                m_err = 1;
                if (hof) m_halt = 1;
            end
            e.pass = m_rp; e.diff = m_diff; e.pc = m_pass; e.fc = m_fail;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        verdict_t e;
        if (result_valid || v2) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_verdict: result_valid=%0b w2=%0b with nothing pending at %0t",
                         result_valid, v2, $time);
            end else begin
                e = q.pop_front();
                chk("result_valid", result_valid, 1);
                chk("result_valid_w2", v2, 1);
                chk("verdict_pass", result_pass, e.pass);
                chk("verdict_diff", diff_mask, e.diff);
                chk("verdict_pass_cnt", pass_cnt, sat(e.pc, 16));
                chk("verdict_fail_cnt", fail_cnt, sat(e.fc, 16));
                chk("verdict_pass_cnt_w2", pc2, sat(e.pc, 2));
                chk("verdict_fail_cnt_w2", fc2, sat(e.fc, 2));
            end
        end
    end

    initial begin
        logic [15:0] a, b, o;
        model_zero();
        drive(0, 16'h0, 16'h0, 16'h0, 0, 0, 0);
        drive(1, 16'h1234, 16'h0001, 16'h1235, 0, 0, 0);
        chk("reset_result_valid", result_valid, 0);
        // three back-to-back passing vectors
        drive(1, 16'h0000, 16'hFFFF, 16'hFFFF, 0, 0, 1);
        drive(1, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 0, 1);
        drive(1, 16'hA38C, 16'hC707, 16'hE78F, 0, 0, 1);
        idle(2);
        chk("plan1_pass_cnt", pass_cnt, 3);
        // failures without halting, capture kept from the first
        drive(1, 16'hA38C, 16'hC707, 16'hE78E, 0, 0, 1);
        chk("plan2_diff", diff_mask, 16'h0001);
        chk("plan2_ff_out", ff_out, 16'hE78E);
        drive(1, 16'hA38C, 16'hC707, 16'h0000, 0, 0, 1);
        idle(1);
        chk("plan2_fail_cnt", fail_cnt, 2);
        chk("plan2_ff_out_kept", ff_out, 16'hE78E);
        // halt on fail, then offered vectors are refused
        drive(0, 16'h0, 16'h0, 16'h0, 0, 1, 1);
        drive(1, 16'h00F0, 16'h0F00, 16'h0000, 1, 0, 1);
        drive(1, 16'h0001, 16'h0002, 16'h0003, 0, 0, 1);
        drive(1, 16'h0001, 16'h0002, 16'h0003, 0, 0, 1);
        drive(1, 16'h0001, 16'h0002, 16'h0000, 1, 0, 1);
        chk("plan3_halted", halted, 1);
        chk("plan3_fail_cnt", fail_cnt, 1);
        drive(0, 16'h0, 16'h0, 16'h0, 0, 1, 1);
        idle(1);
        chk("plan3_unhalted", halted, 0);
        // clear wins over a concurrent vector
        drive(1, 16'h0001, 16'h0002, 16'h0003, 0, 1, 1);
        idle(1);
        chk("plan4_pass_cnt", pass_cnt, 0);
        // reset mid-stream drops the vector
        drive(1, 16'h0001, 16'h0002, 16'h0003, 0, 0, 1);
        drive(1, 16'h0004, 16'h0002, 16'h0006, 0, 0, 0);
        chk("plan5_no_verdict", result_valid, 0);
        // saturation on the 2-bit counter instance
        for (int i = 0; i < 5; i++) drive(1, 16'h1000, 16'h0010 << i, 16'h1000 | (16'h0010 << i), 0, 0, 1);
        idle(1);
        chk("plan5_sat_w2", pc2, 3);
        chk("plan5_cnt_w16", pass_cnt, 5);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            o = ($urandom_range(0, 2) != 0) ? (a | b) : 16'($urandom);
            drive($urandom_range(0, 3) != 0, a, b, o,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 59) != 0);
        end
        idle(3);
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
